pcie_msi_sched: RTL and testbench

PCIE_MSI_SCHED -- requirements
Module: pcie_msi_sched

---
 rtl/pcie_msi_sched.sv | 143 ++++++++++++++
 tb/tb_pcie_msi_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msi_sched.sv
// pcie_msi_sched: round-robin MSI scheduler for a PCIe hard IP.
// Latches interrupt events into a pending register, then issues one MSI at a
// time using a req/ack handshake. Masked vectors stay pending until unmasked.
// Optional feature macro: PCIE_MSI_HOLDOFF_EN. When it is defined, each ack is
// followed by a HOLD period of HOLDOFF_CYCLES cycles before the next grant.
// When it is undefined, HOLD is never entered and HOLDOFF_CYCLES has no effect.
module pcie_msi_sched #(
    parameter int NUM_IRQ        = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               app_msi_req,
    output logic [4:0]         app_msi_num,
    output logic [2:0]         app_msi_tc,
    input  logic               app_msi_ack,
    output logic               app_int_sts,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               busy
);

`ifdef PCIE_MSI_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    // A zero-length holdoff degenerates to a direct return to IDLE, which
    // keeps the macro-defined/HOLDOFF_CYCLES=0 build identical to the plain one.
    localparam int HOLD_LEN = HOLD_EN ? HOLDOFF_CYCLES : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic               req_q;
    logic [4:0]         num_q;
    logic [4:0]         last_grant_q;
    logic [7:0]         hold_cnt_q;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               grant_vld;
    logic [4:0]         grant_idx;
    int                 best_off;
    int                 cand_off;

    assign eligible = pending_q & ~irq_mask;

    // Round-robin pick: the eligible vector closest after last_grant wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 5'd0;
        best_off  = NUM_IRQ;
        cand_off  = 0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            cand_off = (j + NUM_IRQ - 1 - int'(last_grant_q)) % NUM_IRQ;
            if (eligible[j] && (cand_off < best_off)) begin
                best_off  = cand_off;
                grant_idx = 5'(j);
                grant_vld = 1'b1;
            end
        end
    end

    // Pending bits: clear on grant, but a same-cycle new event keeps the bit set.
    always_comb begin
        clr_mask = '0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            clr_mask[j] = (state_q == IDLE) && grant_vld && (grant_idx == 5'(j));
        end
        pending_d = (pending_q & ~clr_mask) | irq;
    end

    // Pending event register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Scheduler FSM with registered request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            num_q        <= 5'd0;
            last_grant_q <= 5'(NUM_IRQ - 1);
            hold_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        req_q        <= 1'b1;
                        num_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (app_msi_ack) begin
                        req_q <= 1'b0;
                        if (HOLD_LEN != 0) begin
                            hold_cnt_q <= 8'(HOLD_LEN);
                            state_q    <= HOLD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q <= 8'd1) begin
                        hold_cnt_q <= 8'd0;
                        state_q    <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign app_msi_req = req_q;
    assign app_msi_num = num_q;
    assign app_msi_tc  = 3'd0;
    assign app_int_sts = 1'b0;
    assign irq_pending = pending_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_msi_sched.sv
// Directed bench for pcie_msi_sched (NUM_IRQ=8, HOLDOFF_CYCLES=16).
// Gap convention: edges from the ack edge up to and including the edge that
// raises the next request, counting the ack edge itself.
module tb_pcie_msi_sched;

    localparam int N  = 8;
    localparam int HO = 16;
`ifdef PCIE_MSI_HOLDOFF_EN
    localparam int HOLD_LEN = HO;
`else
    localparam int HOLD_LEN = 0;
`endif
    localparam int GAP = HOLD_LEN + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq;
    logic [N-1:0] irq_mask;
    logic         app_msi_req;
    logic [4:0]   app_msi_num;
    logic [2:0]   app_msi_tc;
    logic         app_msi_ack;
    logic         app_int_sts;
    logic [N-1:0] irq_pending;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    pcie_msi_sched #(.NUM_IRQ(N), .HOLDOFF_CYCLES(HO)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .irq_mask    (irq_mask),
        .app_msi_req (app_msi_req),
        .app_msi_num (app_msi_num),
        .app_msi_tc  (app_msi_tc),
        .app_msi_ack (app_msi_ack),
        .app_int_sts (app_int_sts),
        .irq_pending (irq_pending),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max_edges, output int edges);
        edges = 0;
        while (!app_msi_req && edges < max_edges) begin
            tick();
            edges++;
        end
    endtask

    task automatic ack_req(input string tag);
        app_msi_ack = 1'b1;
        tick();
        app_msi_ack = 1'b0;
        check_val(tag, 32'(app_msi_req), 32'd0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        irq         = '0;
        irq_mask    = '0;
        app_msi_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int e;
        int seen;
        reset       = 1'b1;
        irq         = '0;
        irq_mask    = '0;
        app_msi_ack = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check_val("rst_req",     32'(app_msi_req), 32'd0);
        check_val("rst_num",     32'(app_msi_num), 32'd0);
        check_val("rst_pending", 32'(irq_pending), 32'd0);
        check_val("rst_busy",    32'(busy),        32'd0);
        check_val("rst_tc",      32'(app_msi_tc),  32'd0);
        check_val("rst_intsts",  32'(app_int_sts), 32'd0);

        // Single pulse on vector 2: one edge latency to request.
        do_reset();
        repeat (6) tick();
        irq = 8'h04;
        tick();
        irq = 8'h00;
        check_val("p2_pend",     32'(irq_pending), 32'h04);
        check_val("p2_req_lat",  32'(app_msi_req), 32'd0);
        tick();
        check_val("p2_req",      32'(app_msi_req), 32'd1);
        check_val("p2_num",      32'(app_msi_num), 32'd2);
        check_val("p2_pend_clr", 32'(irq_pending), 32'h00);
        check_val("p2_busy",     32'(busy),        32'd1);
        repeat (3) tick();
        check_val("p2_hold_req", 32'(app_msi_req), 32'd1);
        check_val("p2_hold_num", 32'(app_msi_num), 32'd2);
        ack_req("p2_ack_drop");
        repeat (HOLD_LEN + 2) tick();
        check_val("p2_idle", 32'(busy), 32'd0);
        // Ack while idle must have no effect.
        app_msi_ack = 1'b1;
        tick();
        tick();
        app_msi_ack = 1'b0;
        check_val("idle_ack_req",  32'(app_msi_req), 32'd0);
        check_val("idle_ack_busy", 32'(busy),        32'd0);

        // All eight vectors at once: issued 0..7 in order, each once.
        do_reset();
        irq = 8'hFF;
        tick();
        irq = 8'h00;
        for (int i = 0; i < N; i++) begin
            wait_req(64, e);
            check_val("all_req", 32'(app_msi_req), 32'd1);
            check_val("all_num", 32'(app_msi_num), 32'(i));
            repeat (3) tick();
            check_val("all_stable", 32'(app_msi_num), 32'(i));
            ack_req("all_ack");
        end
        repeat (HOLD_LEN + 20) tick();
        check_val("all_done_req",  32'(app_msi_req), 32'd0);
        check_val("all_done_pend", 32'(irq_pending), 32'd0);

        // Round robin wrap: grant 3, then pending 0x09 gives 0 before 3.
        do_reset();
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        check_val("rr_num3", 32'(app_msi_num), 32'd3);
        irq = 8'h09;
        tick();
        irq = 8'h00;
        check_val("rr_pend", 32'(irq_pending), 32'h09);
        ack_req("rr_ack1");
        wait_req(64, e);
        check_val("rr_req2",  32'(app_msi_req), 32'd1);
        check_val("rr_num0",  32'(app_msi_num), 32'd0);
        check_val("rr_pend2", 32'(irq_pending), 32'h08);
        ack_req("rr_ack2");
        wait_req(64, e);
        check_val("rr_num3b", 32'(app_msi_num), 32'd3);
        ack_req("rr_ack3");

        // Masked vector stays pending, then fires after unmask.
        do_reset();
        irq_mask = 8'h01;
        irq      = 8'h01;
        tick();
        irq  = 8'h00;
        seen = 0;
        repeat (20) begin
            tick();
            if (app_msi_req) seen = 1;
        end
        check_val("mask_noreq", 32'(seen),        32'd0);
        check_val("mask_pend",  32'(irq_pending), 32'h01);
        irq_mask = 8'h00;
        tick();
        check_val("unmask_req", 32'(app_msi_req), 32'd1);
        check_val("unmask_num", 32'(app_msi_num), 32'd0);
        // Masking during an outstanding request must not withdraw it.
        irq_mask = 8'hFF;
        tick();
        tick();
        check_val("remask_req", 32'(app_msi_req), 32'd1);
        check_val("remask_num", 32'(app_msi_num), 32'd0);
        ack_req("remask_ack");
        irq_mask = 8'h00;

        // Gap between ack and next request.
        do_reset();
        irq = 8'h03;
        tick();
        irq = 8'h00;
        tick();
        check_val("gap_num0", 32'(app_msi_num), 32'd0);
        ack_req("gap_low");
        wait_req(64, e);
        check_val("gap_req",  32'(app_msi_req), 32'd1);
        check_val("gap_len",  32'(e + 1),       32'(GAP));
        check_val("gap_num1", 32'(app_msi_num), 32'd1);
        ack_req("gap_ack2");

        // Asynchronous reset in the middle of a request.
        do_reset();
        irq = 8'hF0;
        tick();
        irq = 8'h00;
        tick();
        check_val("ar_num4", 32'(app_msi_num), 32'd4);
        irq = 8'hF0;
        tick();
        irq = 8'h00;
        check_val("ar_req_pre",  32'(app_msi_req), 32'd1);
        check_val("ar_pend_pre", 32'(irq_pending), 32'hF0);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_req",  32'(app_msi_req), 32'd0);
        check_val("ar_pend", 32'(irq_pending), 32'h00);
        check_val("ar_busy", 32'(busy),        32'd0);
        check_val("ar_num",  32'(app_msi_num), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check_val("ar_quiet", 32'(app_msi_req), 32'd0);
        irq = 8'h20;
        tick();
        irq = 8'h00;
        tick();
        check_val("ar_new_req", 32'(app_msi_req), 32'd1);
        check_val("ar_new_num", 32'(app_msi_num), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
